// File: rtl/baz_defs.sv
// Constants shared by the BAZ pattern transmitter and the det_baz detector.
package baz_defs;

   localparam int              CHAR_W      = 8;
   localparam int              WORD_LEN    = 3;
   localparam logic [23:0]     BAZ_PATTERN = "BAZ";
   localparam logic [7:0]      IDLE_CHAR   = 8'h20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/baz_pattern_rom.sv
// Combinational character select: index 0 is the MSB character of PATTERN.
module baz_pattern_rom #(
   parameter int                        CHAR_W   = 8,
   parameter int                        WORD_LEN = 3,
   parameter int                        IDX_W    = 2,
   parameter logic [WORD_LEN*CHAR_W-1:0] PATTERN = "BAZ"
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [CHAR_W-1:0] ch
);

   logic [CHAR_W-1:0] pattern_chars [WORD_LEN];

   genvar gi;
   generate
      for (gi = 0; gi < WORD_LEN; gi++) begin : g_chars
         assign pattern_chars[gi] = PATTERN[(WORD_LEN-1-gi)*CHAR_W +: CHAR_W];
      end
   endgenerate

   always_comb begin
      ch = '0;
      for (int i = 0; i < WORD_LEN; i++) begin
         if (idx == IDX_W'(i)) ch = pattern_chars[i];
      end
   end

endmodule

// File: rtl/baz_pattern_tx.sv
// Pattern transmitter: sends PATTERN rep_cnt times with gap idle characters between
// repetitions, honouring out_ready backpressure. All outputs are registered.
module baz_pattern_tx #(
   parameter int                                          CHAR_W    = baz_defs::CHAR_W,
   parameter int                                          WORD_LEN  = baz_defs::WORD_LEN,
   parameter logic [WORD_LEN*CHAR_W-1:0]                  PATTERN   = baz_defs::BAZ_PATTERN,
   parameter logic [CHAR_W-1:0]                           IDLE_CHAR = baz_defs::IDLE_CHAR,
   parameter int                                          CNT_W     = 8,
   parameter int                                          GAP_W     = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [CNT_W-1:0]  rep_cnt,
   input  logic [GAP_W-1:0]  gap,
   input  logic              abort,
   input  logic              out_ready,
   output logic [CHAR_W-1:0] out_char,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   import baz_defs::*;

   localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

   state_t            state_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [IDX_W-1:0]  idx_next;
   logic [IDX_W-1:0]  rom_addr;
   logic [CNT_W-1:0]  reps_left_reg;
   logic [GAP_W-1:0]  gap_reg;
   logic [GAP_W-1:0]  gap_left_reg;
   logic [CHAR_W-1:0] rom_char;
   logic              last_char;

   assign last_char = (idx_reg == IDX_W'(WORD_LEN-1));
   assign idx_next  = last_char ? '0 : idx_reg + 1'b1;
   // out_char is registered, so the ROM looks up the character for the coming cycle.
   assign rom_addr  = (state_reg == SEND) ? idx_next : '0;

   baz_pattern_rom #(
      .CHAR_W   (CHAR_W),
      .WORD_LEN (WORD_LEN),
      .IDX_W    (IDX_W),
      .PATTERN  (PATTERN)
   ) u_rom (
      .idx (rom_addr),
      .ch  (rom_char)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         reps_left_reg <= '0;
         gap_reg       <= '0;
         gap_left_reg  <= '0;
         out_char      <= IDLE_CHAR;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            out_char  <= IDLE_CHAR;
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (start) begin
                     reps_left_reg <= rep_cnt;
                     gap_reg       <= gap;
                     idx_reg       <= '0;
                     if (rep_cnt == '0) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                     end else begin
                        state_reg <= SEND;
                        out_char  <= rom_char;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                     end
                  end
               end
               SEND: begin
                  if (out_ready) begin
                     idx_reg <= idx_next;
                     if (!last_char) begin
                        out_char <= rom_char;
                     end else begin
                        reps_left_reg <= reps_left_reg - 1'b1;
                        if (reps_left_reg == CNT_W'(1)) begin
                           state_reg <= DONE;
                           done      <= 1'b1;
                           busy      <= 1'b0;
                           out_valid <= 1'b0;
                           out_char  <= IDLE_CHAR;
                        end else if (gap_reg == '0) begin
                           out_char <= rom_char;
                        end else begin
                           state_reg    <= GAP;
                           gap_left_reg <= gap_reg;
                           out_valid    <= 1'b0;
                           out_char     <= IDLE_CHAR;
                        end
                     end
                  end
               end
               GAP: begin
                  if (out_ready) begin
                     gap_left_reg <= gap_left_reg - 1'b1;
                     if (gap_left_reg == GAP_W'(1)) begin
                        state_reg <= SEND;
                        out_char  <= rom_char;
                        out_valid <= 1'b1;
                     end
                  end
               end
               DONE: state_reg <= IDLE;
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule
